// File: rtl/da_clk_div_pkg.sv
// Shared types and helpers for the DA clock-enable / divided-clock generator.
// Build option: CLK_DIV_PHASE_EN adds per-channel programmable phase offsets.
package da_clk_div_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } clk_div_state_e;

    // Widest divisor the helper accepts; channels cast down to their own width.
    localparam int DIV_MAX_W = 32;

    // Width of the settle counter, which counts 0 .. lock_wait-1.
    function automatic int lock_cnt_w(input int lock_wait);
        return (lock_wait > 1) ? $clog2(lock_wait) : 1;
    endfunction

    // A programmed divisor of 0 behaves as 1.
    function automatic logic [DIV_MAX_W-1:0] div_eff(input logic [DIV_MAX_W-1:0] div);
        return (div == '0) ? DIV_MAX_W'(1) : div;
    endfunction

endpackage

// File: rtl/da_clk_div_chan.sv
// One output channel: counter, shadow/active divisor, pending flag, ce and toggle clock.
// Build option: CLK_DIV_PHASE_EN adds phase shadow/active registers and the cfg phase input.
module da_clk_div_chan
    import da_clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_DIV_PHASE_EN
    input  logic [DIV_W-1:0] wr_phase,
`endif
    output logic             pending,
    output logic             ce,
    output logic             clk_out
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] shadow_div;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] next_div;
    logic [DIV_W-1:0] cur_eff;
    logic [DIV_W-1:0] start_val;
    logic             tc;
    logic             apply;

    assign cur_eff = DIV_W'(div_eff(DIV_MAX_W'(active_div)));
    assign tc      = run && (cnt == cur_eff - ONE);
    // A write in this cycle always waits for a later wrap, so the period only changes at a wrap.
    assign apply    = pending && !wr_en && (!run || sync || tc);
    assign next_div = apply ? shadow_div : active_div;

`ifdef CLK_DIV_PHASE_EN
    logic [DIV_W-1:0] shadow_phase;
    logic [DIV_W-1:0] active_phase;
    logic [DIV_W-1:0] next_phase;
    logic [DIV_W-1:0] next_eff;

    assign next_phase = apply ? shadow_phase : active_phase;
    assign next_eff   = DIV_W'(div_eff(DIV_MAX_W'(next_div)));
    assign start_val  = next_phase % next_eff;
`else
    assign start_val  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            shadow_div   <= DIV_RST;
            active_div   <= DIV_RST;
            pending      <= 1'b0;
            ce           <= 1'b0;
            clk_out      <= 1'b0;
`ifdef CLK_DIV_PHASE_EN
            shadow_phase <= '0;
            active_phase <= '0;
`endif
        end else begin
            if (wr_en) begin
                shadow_div   <= wr_div;
`ifdef CLK_DIV_PHASE_EN
                shadow_phase <= wr_phase;
`endif
                pending      <= 1'b1;
            end else if (apply) begin
                active_div   <= shadow_div;
`ifdef CLK_DIV_PHASE_EN
                active_phase <= shadow_phase;
`endif
                pending      <= 1'b0;
            end

            // Sync outranks a terminal count landing in the same cycle.
            if (!run || sync) begin
                cnt     <= start_val;
                ce      <= 1'b0;
                clk_out <= 1'b0;
            end else if (tc) begin
                cnt     <= '0;
                ce      <= 1'b1;
                clk_out <= ~clk_out;
            end else begin
                cnt     <= cnt + ONE;
                ce      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/da_clk_div_gen.sv
// Multi-channel clock-enable and 50%-duty divided-clock generator gated by PLL lock.
// Build option: CLK_DIV_PHASE_EN adds cfg_phase and per-channel phase offsets.
module da_clk_div_gen
    import da_clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int DIV_W       = 8,
    parameter  int LOCK_WAIT   = 1024,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLK_DIV_PHASE_EN
    input  logic [DIV_W-1:0]  cfg_phase,
`endif
    input  logic              sync_req,
    output logic              run,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic [7:0]        lock_lost_cnt
);

    localparam int             LCW         = lock_cnt_w(LOCK_WAIT);
    localparam logic [LCW-1:0] SETTLE_LAST = LCW'(LOCK_WAIT - 1);
    localparam logic [LCW-1:0] LCW_ONE     = LCW'(1);

    clk_div_state_e    state;
    clk_div_state_e    state_next;
    logic [LCW-1:0]    settle_cnt;
    logic [LCW-1:0]    settle_next;
    logic [1:0]        lock_sync;
    logic              lock_s;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;
    logic              chan_sync;

    assign lock_s    = lock_sync[1];
    assign run       = (state == ST_RUN);
    assign chan_sync = sync_req && run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync     <= 2'b00;
            state         <= ST_WAIT_LOCK;
            settle_cnt    <= '0;
            lock_lost_cnt <= 8'd0;
        end else begin
            lock_sync     <= {lock_sync[0], pll_lock};
            state         <= state_next;
            settle_cnt    <= settle_next;
            if (run && !lock_s && (lock_lost_cnt != 8'hFF))
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        case (state)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next  = ST_SETTLE;
                    settle_next = '0;
                end
            end
            ST_SETTLE: begin
                if (!lock_s)
                    state_next = ST_WAIT_LOCK;
                else if (settle_cnt == SETTLE_LAST)
                    state_next = ST_RUN;
                else
                    settle_next = settle_cnt + LCW_ONE;
            end
            ST_RUN: begin
                if (!lock_s)
                    state_next = ST_WAIT_LOCK;
            end
            default: state_next = ST_WAIT_LOCK;
        endcase
    end

    // Handshake: a transfer happens on a clock edge where cfg_valid && cfg_ready.
    // cfg_ready depends only on the addressed channel's pending flag; channel
    // numbers beyond NUM_CH are always ready and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i))
                cfg_ready = ~pending[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_en[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        da_clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .sync     (chan_sync),
            .wr_en    (wr_en[g]),
            .wr_div   (cfg_div),
`ifdef CLK_DIV_PHASE_EN
            .wr_phase (cfg_phase),
`endif
            .pending  (pending[g]),
            .ce       (ce_out[g]),
            .clk_out  (clk_out[g])
        );
    end

endmodule

// File: tb/tb_da_clk_div_gen.sv
// Directed bench for da_clk_div_gen: lock sequencing, reconfiguration, sync and lock-loss counting.
module tb_da_clk_div_gen;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int LOCK_WAIT   = 16;
    localparam int DEFAULT_DIV = 2;
    localparam int CH_W        = 2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              pll_lock  = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [DIV_W-1:0]  cfg_div   = '0;
    logic              sync_req  = 1'b0;
    logic              cfg_ready;
    logic              run;
    logic [NUM_CH-1:0] ce_out;
    logic [NUM_CH-1:0] clk_out;
    logic [7:0]        lock_lost_cnt;
`ifdef CLK_DIV_PHASE_EN
    logic [DIV_W-1:0]  cfg_phase = '0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    da_clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_WAIT   (LOCK_WAIT),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
`ifdef CLK_DIV_PHASE_EN
        .cfg_phase     (cfg_phase),
`endif
        .sync_req      (sync_req),
        .run           (run),
        .ce_out        (ce_out),
        .clk_out       (clk_out),
        .lock_lost_cnt (lock_lost_cnt)
    );

    // driver helpers: inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_run(input int limit, output int waited);
        waited = 0;
        while (run !== 1'b1 && waited < limit) begin
            tick(1);
            waited++;
        end
    endtask

    task automatic pulse_sync();
        sync_req = 1'b1;
        tick(1);
        sync_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        tick(2);
        tests_run++;
        if (run !== 1'b0 || ce_out !== 4'b0000 || clk_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: run=%b ce=%b clk=%b expected 0/0000/0000", run, ce_out, clk_out);
        end
        tests_run++;
        if (lock_lost_cnt !== 8'd0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cnt_ready: lost=%0d ready=%b expected 0/1", lock_lost_cnt, cfg_ready);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    // lock low for one sampled edge while settling must restart the settle window
    task automatic test_settle_glitch();
        int seen_run;
        seen_run = 0;
        pll_lock = 1'b1;
        tick(8);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            if (run !== 1'b0) seen_run++;
        end
        tests_run++;
        if (seen_run != 0) begin
            tests_failed++;
            $display("FAIL settle_glitch_run: run high on %0d cycles expected 0", seen_run);
        end
        pll_lock = 1'b0;
        tick(4);
        tests_run++;
        if (run !== 1'b0 || lock_lost_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL settle_glitch_lost: run=%b lost=%0d expected 0/0", run, lock_lost_cnt);
        end
    endtask

    // lock sampled at edge 0; run rises on edge 18; default div 2 strobes at run+2
    task automatic test_startup();
        logic [NUM_CH-1:0] exp_ce;
        logic [NUM_CH-1:0] exp_clk;
        pll_lock = 1'b1;
        tick(18);
        tests_run++;
        if (run !== 1'b0) begin
            tests_failed++;
            $display("FAIL startup_run_early: run=%b expected 0", run);
        end
        tick(1);
        tests_run++;
        if (run !== 1'b1) begin
            tests_failed++;
            $display("FAIL startup_run_rise: run=%b expected 1", run);
        end
        for (int m = 1; m <= 8; m++) begin
            tick(1);
            exp_ce  = (m % 2 == 0) ? '1 : '0;
            exp_clk = ((m / 2) % 2 == 1) ? '1 : '0;
            tests_run++;
            if (ce_out !== exp_ce || clk_out !== exp_clk) begin
                tests_failed++;
                $display("FAIL startup_div2 m=%0d: ce=%b clk=%b expected ce=%b clk=%b",
                         m, ce_out, clk_out, exp_ce, exp_clk);
            end
        end
    endtask

    task automatic test_reconfig();
        logic exp_ce1;
        logic exp_clk1;
        pulse_sync();
        tests_run++;
        if (ce_out !== 4'b0000 || clk_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL sync_clear: ce=%b clk=%b expected 0000/0000", ce_out, clk_out);
        end
        cfg_ch  = 2'd1;
        cfg_div = 8'd5;
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reconfig_ready_before: ready=%b expected 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        tests_run++;
        if (cfg_ready !== 1'b0 || ce_out[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reconfig_pending: ready=%b ce1=%b expected 0/0", cfg_ready, ce_out[1]);
        end
        for (int n = 2; n <= 17; n++) begin
            tick(1);
            if (n == 2) begin
                tests_run++;
                if (cfg_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL reconfig_ready_after_wrap: ready=%b expected 1", cfg_ready);
                end
            end
            exp_ce1  = (n == 2 || n == 7 || n == 12 || n == 17);
            exp_clk1 = (n < 7) ? 1'b1 : (n < 12) ? 1'b0 : (n < 17) ? 1'b1 : 1'b0;
            tests_run++;
            if (ce_out[1] !== exp_ce1 || clk_out[1] !== exp_clk1 || ce_out[0] !== (n % 2 == 0)) begin
                tests_failed++;
                $display("FAIL reconfig_div5 n=%0d: ce=%b clk1=%b expected ce1=%b clk1=%b ce0=%b",
                         n, ce_out, clk_out[1], exp_ce1, exp_clk1, (n % 2 == 0));
            end
        end
    endtask

    task automatic test_div_zero();
        pulse_sync();
        cfg_ch    = 2'd2;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        for (int n = 2; n <= 9; n++) begin
            tick(1);
            tests_run++;
            if (ce_out[2] !== 1'b1 || clk_out[2] !== (n % 2 == 0)) begin
                tests_failed++;
                $display("FAIL div_zero n=%0d: ce2=%b clk2=%b expected 1/%b",
                         n, ce_out[2], clk_out[2], (n % 2 == 0));
            end
        end
    endtask

    task automatic test_sync();
        int                divs[NUM_CH];
        logic [NUM_CH-1:0] exp_ce;
        logic [NUM_CH-1:0] exp_clk;
        divs = '{2, 3, 4, 6};
        for (int c = 1; c < NUM_CH; c++) begin
            cfg_ch  = CH_W'(c);
            cfg_div = DIV_W'(divs[c]);
            tests_run++;
            if (cfg_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL sync_cfg_ready ch=%0d: ready=%b expected 1", c, cfg_ready);
            end
            cfg_valid = 1'b1;
            tick(1);
        end
        cfg_valid = 1'b0;
        pulse_sync();
        tests_run++;
        if (ce_out !== 4'b0000 || clk_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL sync_zero: ce=%b clk=%b expected 0000/0000", ce_out, clk_out);
        end
        for (int n = 1; n <= 12; n++) begin
            tick(1);
            for (int c = 0; c < NUM_CH; c++) begin
                exp_ce[c]  = (n % divs[c] == 0);
                exp_clk[c] = ((n / divs[c]) % 2 == 1);
            end
            tests_run++;
            if (ce_out !== exp_ce || clk_out !== exp_clk) begin
                tests_failed++;
                $display("FAIL sync_align n=%0d: ce=%b clk=%b expected ce=%b clk=%b",
                         n, ce_out, clk_out, exp_ce, exp_clk);
            end
        end
    endtask

    task automatic test_lock_loss();
        int waited;
        int timeouts;
        timeouts = 0;
        pll_lock = 1'b0;
        tick(2);
        tests_run++;
        if (run !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_loss_run_hold: run=%b expected 1", run);
        end
        tick(1);
        tests_run++;
        if (run !== 1'b0 || lock_lost_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL lock_loss_first: run=%b lost=%0d expected 0/1", run, lock_lost_cnt);
        end
        tick(1);
        tests_run++;
        if (ce_out !== 4'b0000 || clk_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL lock_loss_outputs: ce=%b clk=%b expected 0000/0000", ce_out, clk_out);
        end
        for (int i = 2; i <= 300; i++) begin
            pll_lock = 1'b1;
            wait_run(40, waited);
            if (waited >= 40) timeouts++;
            pll_lock = 1'b0;
            tick(4);
            if (i == 254 || i == 255 || i == 300) begin
                tests_run++;
                if (lock_lost_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
                    tests_failed++;
                    $display("FAIL lock_loss_count i=%0d: lost=%0d expected %0d",
                             i, lock_lost_cnt, (i > 255) ? 255 : i);
                end
            end
        end
        tests_run++;
        if (timeouts != 0) begin
            tests_failed++;
            $display("FAIL lock_loss_relock_timeout: %0d timeouts expected 0", timeouts);
        end
        // relock keeps the programmed divisors 2,3,4,6
        pll_lock = 1'b1;
        wait_run(40, waited);
        tests_run++;
        if (run !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_run: run=%b expected 1 after %0d cycles", run, waited);
        end
        tick(2);
        tests_run++;
        if (ce_out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL relock_ce_m2: ce=%b expected 0001", ce_out);
        end
        tick(1);
        tests_run++;
        if (ce_out !== 4'b0010 || lock_lost_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL relock_ce_m3: ce=%b lost=%0d expected 0010/255", ce_out, lock_lost_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        #1;
        tests_run++;
        if (run !== 1'b0 || ce_out !== 4'b0000 || clk_out !== 4'b0000 || lock_lost_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: run=%b ce=%b clk=%b lost=%0d expected all 0",
                     run, ce_out, clk_out, lock_lost_cnt);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_settle_glitch();
        test_startup();
        test_reconfig();
        test_div_zero();
        test_sync();
        test_lock_loss();
        test_reset_mid();
        test_startup();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
